// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
// Mode encodings and a width helper that never returns zero.
package ctr_pkg;

    localparam int CtrWrap = 0;
    localparam int CtrSat  = 1;

    // Register width needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/updown_mod_ctr_prescaler.sv
// Enable prescaler: tick_o fires on every Div-th enabled cycle.
// clr_i returns the divider to its start phase.
module prescaler
    import ctr_pkg::*;
#(
    parameter int Div = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PreW = clog2_safe(Div);
    localparam logic [PreW-1:0] LastPhase = PreW'(Div - 1);

    logic [PreW-1:0] cnt_q;

    // Combinational so a cascaded stage sees the step in the same cycle.
    assign tick_o = en_i && (cnt_q == LastPhase);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_mod_ctr.sv
// Synchronous up/down counter with programmable modulus, prescaler, clamped load,
// clear, and wrap or saturate behaviour at the terminal value.
module updown_mod_ctr
    import ctr_pkg::*;
#(
    parameter int Width    = 4,
    parameter int Modulus  = 2 ** Width,
    parameter int Div      = 1,
    parameter int Saturate = CtrWrap
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] MaxVal = Width'(Modulus - 1);

    logic             step_fire;
    logic             at_term;
    logic [Width-1:0] terminal;
    logic [Width-1:0] load_clamped;
    logic [Width-1:0] step_val;
    logic [Width-1:0] count_q;
    logic             wrap_q;

    prescaler #(
        .Div(Div)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (en_i),
        .clr_i (clr_i | load_i),
        .tick_o(step_fire)
    );

    assign terminal = up_i ? MaxVal : '0;
    assign at_term  = (count_q == terminal);
    assign tc_o     = step_fire & at_term;

    // A full-range modulus cannot be exceeded by any load value.
    generate
        if (Modulus < (2 ** Width)) begin : g_clamp
            assign load_clamped = (load_val_i > MaxVal) ? MaxVal : load_val_i;
        end else begin : g_full
            assign load_clamped = load_val_i;
        end
    endgenerate

    always_comb begin
        step_val = count_q;
        if (at_term) begin
            if (Saturate == CtrWrap) begin
                step_val = up_i ? '0 : MaxVal;
            end
        end else begin
            step_val = up_i ? (count_q + 1'b1) : (count_q - 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (clr_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (load_i) begin
            count_q <= load_clamped;
            wrap_q  <= 1'b0;
        end else begin
            // Pulses for a wrap and for every step attempted while saturated.
            wrap_q <= tc_o;
            if (step_fire) begin
                count_q <= step_val;
            end
        end
    end

    assign o      = count_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_updown_mod_ctr.sv
// Bench for updown_mod_ctr: three instances (wrap, saturate, divide-by-3) share
// stimulus and are checked against an integer model of the counting rules.
module tb_updown_mod_ctr;

    localparam int N = 3;
    localparam int MODS [N] = '{10, 10, 10};
    localparam int DIVS [N] = '{1, 1, 3};
    localparam int SATS [N] = '{0, 1, 0};

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] o_a [N];
    logic       tc_a [N];
    logic       wrap_a [N];

    updown_mod_ctr #(.Width(4), .Modulus(10), .Div(1), .Saturate(0)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(load_val), .o(o_a[0]), .tc_o(tc_a[0]), .wrap_o(wrap_a[0])
    );

    updown_mod_ctr #(.Width(4), .Modulus(10), .Div(1), .Saturate(1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(load_val), .o(o_a[1]), .tc_o(tc_a[1]), .wrap_o(wrap_a[1])
    );

    updown_mod_ctr #(.Width(4), .Modulus(10), .Div(3), .Saturate(0)) dut_div3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
        .load_val_i(load_val), .o(o_a[2]), .tc_o(tc_a[2]), .wrap_o(wrap_a[2])
    );

    // Reference model: count value, enabled-cycle phase, last-edge event flag.
    int   m_cnt [N];
    int   m_pre [N];
    logic m_wrap [N];

    logic [3:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic int m_target(input int i);
        return up ? m_cnt[i] + 1 : m_cnt[i] - 1;
    endfunction

    function automatic logic m_steps(input int i);
        return en && (((m_pre[i] + 1) % DIVS[i]) == 0);
    endfunction

    function automatic logic model_tc(input int i);
        int t;
        t = m_target(i);
        return m_steps(i) && (t < 0 || t >= MODS[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_pre[i]  = 0;
            m_wrap[i] = 1'b0;
        end
    endtask

    // Driver tasks
    task automatic drive(input logic e, input logic u, input logic c, input logic l,
                         input logic [3:0] v);
        en = e; up = u; clr = c; load = l; load_val = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Advance one clock edge: model computes from current inputs, then DUT samples.
    task automatic edge_update();
        int   nc [N];
        int   np [N];
        logic nw [N];
        int   t;
        for (int i = 0; i < N; i++) begin
            nc[i] = m_cnt[i];
            np[i] = m_pre[i];
            nw[i] = 1'b0;
            if (clr) begin
                nc[i] = 0;
                np[i] = 0;
            end else if (load) begin
                nc[i] = (int'(load_val) > MODS[i] - 1) ? MODS[i] - 1 : int'(load_val);
                np[i] = 0;
            end else if (en) begin
                np[i] = (m_pre[i] + 1) % DIVS[i];
                if (np[i] == 0) begin
                    t = m_target(i);
                    if (t < 0 || t >= MODS[i]) begin
                        nw[i] = 1'b1;
                        nc[i] = (SATS[i] != 0) ? m_cnt[i] : (t + MODS[i]) % MODS[i];
                    end else begin
                        nc[i] = t;
                    end
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = nc[i];
            m_pre[i]  = np[i];
            m_wrap[i] = nw[i];
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (o_a[i] !== 4'd0)
                $display("FAIL reset_o[%0d]: got %0d expected 0", i, o_a[i]);
            if (o_a[i] !== 4'd0) n_errors++;
            n_checks++;
            if (wrap_a[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_wrap[%0d]: got %0b expected 0", i, wrap_a[i]);
            end
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_checks++;
            if (tc_a[0] !== (k == 9)) begin
                n_errors++;
                $display("FAIL up_tc k=%0d: got %0b expected %0b", k, tc_a[0], (k == 9));
            end
            edge_update();
            exp_q.push_back(4'((k + 1) % 10));
            n_checks++;
            if (o_a[0] !== exp_q[0]) begin
                n_errors++;
                $display("FAIL up_o k=%0d: got %0d expected %0d", k, o_a[0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_checks++;
            if (wrap_a[0] !== (k == 9)) begin
                n_errors++;
                $display("FAIL up_wrap k=%0d: got %0b expected %0b", k, wrap_a[0], (k == 9));
            end
        end
    endtask

    task automatic test_count_down();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        edge_update();
        n_checks++;
        if (o_a[0] !== 4'd2) begin
            n_errors++;
            $display("FAIL down_load: got %0d expected 2", o_a[0]);
        end
        exp_q = '{4'd1, 4'd0, 4'd9, 4'd8};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_checks++;
            if (tc_a[0] !== (k == 2)) begin
                n_errors++;
                $display("FAIL down_tc k=%0d: got %0b expected %0b", k, tc_a[0], (k == 2));
            end
            edge_update();
            n_checks++;
            if (o_a[0] !== exp_q[0]) begin
                n_errors++;
                $display("FAIL down_o k=%0d: got %0d expected %0d", k, o_a[0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_checks++;
            if (wrap_a[0] !== (k == 2)) begin
                n_errors++;
                $display("FAIL down_wrap k=%0d: got %0b expected %0b", k, wrap_a[0], (k == 2));
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
        edge_update();
        n_checks++;
        if (o_a[1] !== 4'd8) begin
            n_errors++;
            $display("FAIL sat_load: got %0d expected 8", o_a[1]);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_checks++;
            if (tc_a[1] !== (k >= 1)) begin
                n_errors++;
                $display("FAIL sat_tc k=%0d: got %0b expected %0b", k, tc_a[1], (k >= 1));
            end
            edge_update();
            n_checks++;
            if (o_a[1] !== 4'd9) begin
                n_errors++;
                $display("FAIL sat_o k=%0d: got %0d expected 9", k, o_a[1]);
            end
            n_checks++;
            if (wrap_a[1] !== (k >= 1)) begin
                n_errors++;
                $display("FAIL sat_wrap k=%0d: got %0b expected %0b", k, wrap_a[1], (k >= 1));
            end
        end
    endtask

    task automatic test_priority_clamp();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        edge_update();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (o_a[i] !== 4'd9) begin
                n_errors++;
                $display("FAIL clamp_o[%0d]: got %0d expected 9", i, o_a[i]);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        edge_update();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (o_a[i] !== 4'd0 || wrap_a[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL clr_prio[%0d]: got o=%0d wrap=%0b expected o=0 wrap=0",
                         i, o_a[i], wrap_a[i]);
            end
        end
    endtask

    task automatic test_prescaler();
        logic [10:0] en_pat;
        en_pat = 11'b11111001111;  // four enabled, two idle, five enabled (LSB first)
        do_reset();
        for (int k = 0; k < 11; k++) begin
            drive(en_pat[k], 1'b1, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            n_checks++;
            if (tc_a[2] !== model_tc(2)) begin
                n_errors++;
                $display("FAIL div_tc k=%0d: got %0b expected %0b", k, tc_a[2], model_tc(2));
            end
            edge_update();
            exp_q.push_back(4'(m_cnt[2]));
            n_checks++;
            if (o_a[2] !== exp_q[0]) begin
                n_errors++;
                $display("FAIL div_o k=%0d: got %0d expected %0d", k, o_a[2], exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (o_a[2] !== 4'd3) begin
            n_errors++;
            $display("FAIL div_final: got %0d expected 3", o_a[2]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        edge_update();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_a[0] !== 4'd0 || wrap_a[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL async_rst: got o=%0d wrap=%0b expected o=0 wrap=0", o_a[0], wrap_a[0]);
        end
        model_reset();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        edge_update();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            edge_update();
            n_checks++;
            if (o_a[0] !== 4'(k + 1)) begin
                n_errors++;
                $display("FAIL async_resume k=%0d: got %0d expected %0d", k, o_a[0], k + 1);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 19) == 0),
                  4'($urandom_range(0, 15)));
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (tc_a[i] !== model_tc(i)) begin
                    n_errors++;
                    $display("FAIL rnd_tc[%0d] k=%0d: got %0b expected %0b",
                             i, k, tc_a[i], model_tc(i));
                end
            end
            edge_update();
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (o_a[i] !== 4'(m_cnt[i]) || wrap_a[i] !== m_wrap[i]) begin
                    n_errors++;
                    $display("FAIL rnd_state[%0d] k=%0d: got o=%0d wrap=%0b expected o=%0d wrap=%0b",
                             i, k, o_a[i], wrap_a[i], m_cnt[i], m_wrap[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_priority_clamp();
        test_prescaler();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_ctr.md
Name: updown_mod_ctr

Overview:
- Synchronous, parametrised up/down counter.
- Programmable modulus, prescaler, parallel load, synchronous clear, and wrap or saturate mode.
- Provides a combinational carry (tc_o) for cascading and a registered wrap pulse for event logging.
- Successor to the basic ripple counter:
  - fully synchronous, single clock domain;
  - intended for timers, dividers and multi-digit (e.g. BCD) counter chains.

Parameters:
- Width, 4, bit width of count output.
- Modulus, 2**Width, count range is 0..Modulus-1. Legal range is 2..2**Width.
- Div, 1, prescaler ratio: the count advances once per Div enabled cycles. Legal range is >=1.
- Saturate, 0, 0 = wrap at the ends; 1 = hold at 0 / Modulus-1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  count enable, feeds the prescaler.
- up_i  input  1  direction: 1 = increment, 0 = decrement.
- clr_i  input  1  synchronous clear.
- load_i  input  1  synchronous parallel load.
- load_val_i  input  Width  value to load.
- o  output  Width  current count, registered.
- tc_o  output  1  terminal-count carry, combinational.
- wrap_o  output  1  one-cycle registered pulse on wrap or saturation hit.

Behaviour:
- Reset
  - Asynchronous, active-low: one clock, reset is asynchronous and active-low.
  - While rst_ni=0: o=0, prescaler=0, wrap_o=0.
  - Deassertion takes effect at the next rising edge.
- Priority per edge
  - clr_i > load_i > count step.
  - clr_i: o<=0, prescaler<=0, wrap_o<=0.
  - load_i: o<=min(load_val_i, Modulus-1), prescaler<=0, wrap_o<=0.
- Prescaler
  - Internal counter, width clog2(Div) (min 1).
  - Increments on each cycle with en_i=1. The step fires when prescaler==Div-1 and en_i=1; the prescaler then returns to 0.
  - For Div=1 every enabled cycle is a step.
  - en_i=0: prescaler and o hold.
- Terminal
  - The terminal value is Modulus-1 when up_i=1, and 0 when up_i=0.
- Step when not at terminal
  - o<=o+1 (up) or o-1 (down).
- Step at terminal
  - Saturate=0: o wraps to 0 (up) or Modulus-1 (down), and wrap_o<=1 for exactly one cycle.
  - Saturate=1: o holds, and wrap_o<=1 on every step attempted at terminal.
- wrap_o is 0 in every cycle without such an event.
- tc_o = step_fire & (o==terminal), combinational, same cycle. Chain tc_o into en_i of the next stage for cascading.
- Direction change
  - up_i is sampled on the stepping edge only.
  - Changing up_i mid-prescale does not reset the prescaler.
- Out-of-range state
  - Unreachable, since load is clamped.
  - No extra recovery logic is required beyond the clamp.
- Arithmetic
  - All compares and increments are done at Width bits.
  - Modulus-1 is computed as a Width-bit localparam.
  - When Modulus=2**Width, the wrap is the natural overflow.
- Reset mid-operation: the asynchronous reset overrides everything immediately, including a pending load or clear.

Decomposition:
- Shared package ctr_pkg holds:
  - mode constants CtrWrap=0 and CtrSat=1;
  - a clog2-safe width helper.
- Sub-module prescaler (prescaler, parameter Div, ports clk_i/rst_ni/en_i/clr_i/tick_o):
  - clr_i is driven by clr_i|load_i;
  - its tick_o provides step_fire.
- The count and terminal logic stays in updown_mod_ctr.

Test Plan (Width=4, Modulus=10, Div=1, Saturate=0 unless stated):
- Reset and count up
  - Stimulus: rst_ni low 1 ns, then en_i=1, up_i=1 for 12 cycles.
  - Response: o = 0,1,...,9,0,1,2. tc_o=1 only in the cycle where o=9. wrap_o=1 in the cycle o=0 is first shown after 9.
- Count down wrap
  - Stimulus: load 2, then up_i=0 for 4 steps.
  - Response: o = 2,1,0,9,8. tc_o=1 in the cycle with o=0.
- Saturate mode (Saturate=1)
  - Stimulus: load 8, up_i=1, 4 steps.
  - Response: o = 8,9,9,9. wrap_o pulses on each step attempted at 9. o never reaches 0.
- Priority and clamp
  - Stimulus: load_val_i=15 with load_i=1; next cycle clr_i=1, load_i=1, en_i=1.
  - Response: o=9 after the first edge, then o=0.
- Prescaler (Div=3)
  - Stimulus: en_i=1 for 9 cycles, with en_i=0 inserted for 2 cycles after cycle 4.
  - Response: o increments only on every 3rd enabled cycle. Final o=3. Prescaler is held during en_i=0.
- Async reset mid-count
  - Stimulus: at o=5, pull rst_ni low between clock edges.
  - Response: o=0 and wrap_o=0 immediately, without waiting for a clock edge. Counting resumes from 0 after release.
